prac_serial_tx: RTL and testbench
=================================

// Module: prac_serial_tx
// PURPOSE
//  Serial frame transmitter: the generator that drives the serial input x of
//    the clocked sequence-detector circuits (inputs a,b,x / output y).
//  Loads a parallel word on a start handshake and shifts it out MSB-first, one
//    bit per clock. Optionally appends an even-parity bit, then holds a
//    programmable idle gap.
//  Used both as a bench stimulus source and as the on-chip driver for detectors.
// PARAMETERS
//  WIDTH      8  data bits per frame; legal range 1..32
//  PARITY_EN  0  1 = append one even-parity bit after the data bits
//  GAP_CYCLES 2  idle cycles after the last frame bit before ready returns; 0 allowed
// PORTS
//  clk    in   1      rising-edge clock; the only clock
//  rst    in   1      synchronous, active-high reset
//  start  in   1      request to send; accepted only when ready=1
//  data   in   WIDTH  frame payload; sampled only on the accepting edge
//  ready  out  1      1 = IDLE, start will be accepted
//  busy   out  1      1 = in SHIFT or GAP (always equal to ~ready)
//  x      out  1      serial bit; 0 whenever valid=0
//  valid  out  1      1 = x carries a frame bit this cycle
//  last   out  1      1-cycle pulse, coincident with the final frame bit
// BEHAVIOUR
//  Reset (rst=1 at a clk edge, any state):
//    - next state IDLE; ready=1; busy=x=valid=last=0
//    - shift register, bit counter and gap counter cleared
//    - rst has priority over start
//  Frame length: N = WIDTH + PARITY_EN.
//  States:
//    - IDLE:  ready=1. On start=1: load data into shreg, compute
//             parity = ^data, clear bit counter, go to SHIFT.
//    - SHIFT: valid=1, x = shreg MSB. Shift left each cycle; bitcnt increments.
//             Bits 0..WIDTH-1 are data[WIDTH-1]..data[0]. If PARITY_EN=1,
//             bit WIDTH is the parity bit (even parity: data ones + parity
//             bit is even).
//             last=1 when bitcnt == N-1. Exit: GAP if GAP_CYCLES>0, else IDLE.
//    - GAP:   valid=0, x=0, busy=1. Stay GAP_CYCLES cycles, then go to IDLE.
//  Latency: start accepted at edge E. First bit is valid in the cycle after E.
//    ready returns N+GAP_CYCLES cycles after that.
//  Back-to-back (GAP_CYCLES=0): start may be held high. The next frame's
//    first bit follows last by exactly one ready cycle (1 idle cycle).
//  start while busy is ignored (not queued). data changes while busy have no
//    effect on the frame in flight.
//  WIDTH=1, PARITY_EN=0: single-bit frame; valid and last both high for 1 cycle.
//  rst mid-frame: frame aborted at that edge. No last pulse; x=0 next cycle.
//  Counters are sized $clog2(WIDTH+2); they never wrap within a legal frame.
//  All outputs are registered; no combinational path from start/data to outputs.
// STRUCTURE
//  Package prac_serial_pkg:
//    - state encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_GAP=2'd2
//    - function cnt_w(n) returning the counter width
//  Sub-module prac_bit_counter:
//    - loadable up-counter with terminal-count compare
//    - instanced twice: bit counter (terminal N-1) and gap counter
//      (terminal GAP_CYCLES-1)
//  The FSM and shift register stay in the top module.
// TESTING
//  1. Reset: rst=1 for 3 cycles with start=1 -> ready=1, valid=0, x=0,
//     last=0 throughout; no frame starts.
//  2. WIDTH=8, PARITY_EN=0, data=8'hA5, start 1 cycle -> x=1,0,1,0,0,1,0,1
//     on cycles 1..8; last only on cycle 8; ready=1 again at cycle 11 (gap 2).
//  3. PARITY_EN=1, data=8'h07 -> 8 data bits 0,0,0,0,0,1,1,1, then parity
//     bit 1 on cycle 9 with last=1; data=8'hA5 gives parity bit 0.
//  4. GAP_CYCLES=0, start held high, data 8'hFF then 8'h00 -> 8 ones,
//     one cycle valid=0, 8 zeros; exactly 2 last pulses.
//  5. start pulsed at bit 3 of an 8'h3C frame with data=8'hFF -> frame
//     unchanged (0,0,1,1,1,1,0,0); no second frame starts.
//  6. rst asserted on bit 4 of 8'hA5 -> next cycle valid=0, x=0, ready=1;
//     no last pulse; a new start then sends a full clean frame.

Source files
------------

// File: rtl/prac_serial_pkg.sv
// rtl/prac_serial_pkg.sv - shared state encoding and counter sizing for the serial transmitter
package prac_serial_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Wide enough to hold a frame index up to n+1 without wrapping.
  function automatic int cnt_w(input int n);
    return $clog2(n + 2);
  endfunction

endpackage

// File: rtl/prac_bit_counter.sv
// rtl/prac_bit_counter.sv - clearable up-counter with a fixed terminal-count compare
module prac_bit_counter
  import prac_serial_pkg::*;
#(
  parameter int           W    = 4,
  parameter logic [W-1:0] TERM = '0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TERM);

endmodule

// File: rtl/prac_serial_tx.sv
// rtl/prac_serial_tx.sv - MSB-first serial frame transmitter with optional even parity and idle gap
module prac_serial_tx
  import prac_serial_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PARITY_EN  = 0,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             x_o,
  output logic             valid_o,
  output logic             last_o
);

  localparam int N  = WIDTH + PARITY_EN;
  localparam int BW = cnt_w(WIDTH);
  localparam int GW = cnt_w((GAP_CYCLES > WIDTH) ? GAP_CYCLES : WIDTH);
  localparam logic [BW-1:0] BIT_TERM = BW'(N - 1);
  localparam logic [GW-1:0] GAP_TERM = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [1:0]   state_q, state_d;
  logic [N-1:0] shreg_q, shreg_d;
  logic [N-1:0] load_word;
  logic         accept;
  logic         bit_tc;
  logic         gap_tc;

  // Parity rides in the LSB so it falls out of the same MSB-first shift.
  if (PARITY_EN != 0) begin : g_par
    assign load_word = {data_i, ^data_i};
  end else begin : g_nopar
    assign load_word = data_i;
  end

  assign accept = (state_q == ST_IDLE) && start_i;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SHIFT;
          shreg_d = load_word;
        end
      end
      ST_SHIFT: begin
        shreg_d = shreg_q << 1;
        if (bit_tc) begin
          state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_tc) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  prac_bit_counter #(.W(BW), .TERM(BIT_TERM)) u_bit_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (accept),
    .en_i  (state_q == ST_SHIFT),
    .tc_o  (bit_tc)
  );

  prac_bit_counter #(.W(GW), .TERM(GAP_TERM)) u_gap_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (state_q == ST_SHIFT),
    .en_i  (state_q == ST_GAP),
    .tc_o  (gap_tc)
  );

  // Outputs decode flop state only; start/data never reach them combinationally.
  assign ready_o = (state_q == ST_IDLE);
  assign busy_o  = ~ready_o;
  assign valid_o = (state_q == ST_SHIFT);
  assign x_o     = valid_o & shreg_q[N-1];
  assign last_o  = valid_o & bit_tc;

endmodule

// File: tb/tb_prac_serial_tx.sv
// tb/tb_prac_serial_tx.sv - scoreboard bench for prac_serial_tx over four parameter sets
module tb_prac_serial_tx;

  localparam int NI = 4;
  localparam int WS [NI] = '{8, 8, 8, 1};
  localparam int PS [NI] = '{0, 1, 0, 0};
  localparam int GS [NI] = '{2, 2, 0, 0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start [NI];
  logic [7:0] data  [NI];
  logic       ready [NI];
  logic       busy  [NI];
  logic       x     [NI];
  logic       valid [NI];
  logic       last  [NI];

  logic [1:0] expq [NI][$];
  int         last_cnt [NI] = '{0, 0, 0, 0};
  bit         mon_en = 1'b0;
  int         n_pass = 0;
  int         n_total = 0;

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [1:0] e;

    prac_serial_tx #(.WIDTH(WS[g]), .PARITY_EN(PS[g]), .GAP_CYCLES(GS[g])) u_dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start[g]),
      .data_i  (data[g][WS[g]-1:0]),
      .ready_o (ready[g]),
      .busy_o  (busy[g]),
      .x_o     (x[g]),
      .valid_o (valid[g]),
      .last_o  (last[g])
    );

    always @(negedge clk) begin
      if (mon_en) begin
        check($sformatf("busy_not_ready[%0d]", g), busy[g], !ready[g]);
        if (valid[g]) begin
          if (expq[g].size() == 0) begin
            check($sformatf("unexpected_bit[%0d]", g), 1, 0);
          end else begin
            e = expq[g].pop_front();
            check($sformatf("x[%0d]", g), x[g], e[1]);
            check($sformatf("last[%0d]", g), last[g], e[0]);
          end
          if (last[g]) last_cnt[g]++;
        end else begin
          check($sformatf("idle_x[%0d]", g), x[g], 0);
          check($sformatf("idle_last[%0d]", g), last[g], 0);
        end
      end
    end
  end

  // Expected bits are the hand-written payload, MSB first, plus a hand-computed parity bit.
  task automatic push_frame(input int i, input logic [7:0] d, input logic par);
    for (int b = WS[i] - 1; b >= 0; b--) begin
      expq[i].push_back({d[b], (PS[i] == 0 && b == 0) ? 1'b1 : 1'b0});
    end
    if (PS[i] != 0) expq[i].push_back({par, 1'b1});
  endtask

  task automatic accept(input int i, input logic [7:0] d, input logic par);
    int guard = 0;
    while (!ready[i] && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check($sformatf("ready_timeout[%0d]", i), 0, 1);
    start[i] = 1'b1;
    data[i]  = d;
    push_frame(i, d, par);
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int guard = 0;
    while (!(ready[i] && expq[i].size() == 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check($sformatf("idle_timeout[%0d]", i), 0, 1);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b1;
      data[i]  = 8'hFF;
    end

    // Reset held with start asserted: nothing may launch.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        check($sformatf("rst_ready[%0d]", i), ready[i], 1);
        check($sformatf("rst_valid[%0d]", i), valid[i], 0);
        check($sformatf("rst_x[%0d]", i), x[i], 0);
        check($sformatf("rst_last[%0d]", i), last[i], 0);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < NI; i++) start[i] = 1'b0;
    mon_en = 1'b1;

    // A5 with gap 2: ready returns on cycle 11.
    accept(0, 8'hA5, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      if (k > 1) @(negedge clk);
      check($sformatf("a5_ready_c%0d", k), ready[0], (k == 11) ? 1 : 0);
    end
    wait_idle(0);

    // Parity: 07 has three ones -> 1, A5 has four ones -> 0.
    accept(1, 8'h07, 1'b1);
    wait_idle(1);
    accept(1, 8'hA5, 1'b0);
    wait_idle(1);
    check("par_last_cnt", last_cnt[1], 2);

    // Start and new data during bit 3 of a 3C frame must be ignored.
    accept(0, 8'h3C, 1'b0);
    repeat (3) @(negedge clk);
    start[0] = 1'b1;
    data[0]  = 8'hFF;
    @(negedge clk);
    start[0] = 1'b0;
    data[0]  = 8'h00;
    wait_idle(0);
    repeat (4) @(negedge clk);
    check("busy_start_ignored_q", expq[0].size(), 0);
    check("busy_start_ready", ready[0], 1);
    check("busy_start_last_cnt", last_cnt[0], 2);

    // Reset on bit 4 aborts the frame: only bits 0..4 appear, no last.
    accept(0, 8'hA5, 1'b0);
    repeat (3) @(negedge clk);
    repeat (3) void'(expq[0].pop_back());
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_valid", valid[0], 0);
    check("abort_x", x[0], 0);
    check("abort_ready", ready[0], 1);
    check("abort_q", expq[0].size(), 0);
    rst = 1'b0;
    accept(0, 8'hA5, 1'b0);
    wait_idle(0);
    check("abort_last_cnt", last_cnt[0], 3);

    // Gap 0 with start held: FF, one idle cycle, 00.
    @(negedge clk);
    start[2] = 1'b1;
    data[2]  = 8'hFF;
    push_frame(2, 8'hFF, 1'b0);
    push_frame(2, 8'h00, 1'b0);
    @(negedge clk);
    data[2] = 8'h00;
    for (int k = 1; k <= 17; k++) begin
      if (k > 1) @(negedge clk);
      check($sformatf("b2b_valid_c%0d", k), valid[2], (k != 9) ? 1 : 0);
      if (k == 10) start[2] = 1'b0;
    end
    wait_idle(2);
    check("b2b_last_cnt", last_cnt[2], 2);

    // Single-bit frames: valid and last together for one cycle.
    accept(3, 8'h01, 1'b0);
    check("w1_valid", valid[3], 1);
    check("w1_last", last[3], 1);
    accept(3, 8'h00, 1'b0);
    wait_idle(3);
    check("w1_last_cnt", last_cnt[3], 2);

    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) check($sformatf("final_q[%0d]", i), expq[i].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
